// File: rtl/iob_pcie_tx_ctrl_pkg.sv
// Shared types and constants for the PCIe TX sequencer.
// Also provides the word-length to beat-count conversion.
package iob_pcie_tx_ctrl_pkg;

    localparam int DATA_W           = 32;
    localparam int C_PCI_DATA_WIDTH = 64;
    localparam int BUF_DEPTH        = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } tx_state_t;

    // Two 32-bit words per beat; an odd trailing word still costs a full beat.
    function automatic logic [DATA_W-1:0] beat_count(input logic [DATA_W-1:0] len);
        return {1'b0, len[DATA_W-1:1]} + {{(DATA_W-1){1'b0}}, len[0]};
    endfunction

endpackage

// File: rtl/iob_pcie_tx_ctrl_if.sv
// FIFO read port plus RIFFA channel TX signals.
// The master side is the sequencer; the slave side is the FIFO/channel environment.
interface iob_pcie_tx_ctrl_if;
    import iob_pcie_tx_ctrl_pkg::*;

    logic                        fifo_empty_i;
    logic [C_PCI_DATA_WIDTH-1:0] fifo_data_i;
    logic                        fifo_ren_o;
    logic                        chnl_tx_o;
    logic                        chnl_tx_last_o;
    logic [DATA_W-1:0]           chnl_tx_len_o;
    logic [DATA_W-2:0]           chnl_tx_off_o;
    logic [C_PCI_DATA_WIDTH-1:0] chnl_tx_data_o;
    logic                        chnl_tx_data_valid_o;
    logic                        chnl_tx_data_ren_i;
    logic                        chnl_tx_ack_i;

    modport master (
        input  fifo_empty_i, fifo_data_i, chnl_tx_data_ren_i, chnl_tx_ack_i,
        output fifo_ren_o, chnl_tx_o, chnl_tx_last_o, chnl_tx_len_o, chnl_tx_off_o,
               chnl_tx_data_o, chnl_tx_data_valid_o
    );

    modport slave (
        output fifo_empty_i, fifo_data_i, chnl_tx_data_ren_i, chnl_tx_ack_i,
        input  fifo_ren_o, chnl_tx_o, chnl_tx_last_o, chnl_tx_len_o, chnl_tx_off_o,
               chnl_tx_data_o, chnl_tx_data_valid_o
    );

endinterface

// File: rtl/iob_pcie_tx_buf.sv
// Two-entry in-order beat buffer fed by a one-cycle-latency FIFO read port.
// Tracks occupancy and whether a read is still in flight.
module iob_pcie_tx_buf
    import iob_pcie_tx_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd,
    input  logic                        pop,
    input  logic [C_PCI_DATA_WIDTH-1:0] data_in,
    output logic [C_PCI_DATA_WIDTH-1:0] head,
    output logic [1:0]                  count,
    output logic                        in_flight
);

    logic [C_PCI_DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic                        wr_ptr;
    logic                        rd_ptr;

    // Read data arrives one cycle after rd, so the load is keyed off in_flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            in_flight <= rd;
            if (in_flight) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({in_flight, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/iob_pcie_tx_ctrl.sv
// RIFFA TX sequencer: request/ack handshake, FIFO prefetch and beat streaming.
// Raises done_o for one cycle after the final beat is consumed.
module iob_pcie_tx_ctrl
    import iob_pcie_tx_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [DATA_W-1:0]  len_i,
    input  logic               last_i,
    output logic               busy_o,
    output logic               done_o,
    iob_pcie_tx_ctrl_if.master tx
);

    tx_state_t                   state;
    tx_state_t                   state_nxt;
    logic [DATA_W-1:0]           len_q;
    logic                        last_q;
    logic [DATA_W-1:0]           beat_cnt;
    logic [DATA_W-1:0]           fetch_cnt;
    logic [1:0]                  buf_count;
    logic                        in_flight;
    logic [C_PCI_DATA_WIDTH-1:0] head;
    logic                        accept;
    logic                        valid;
    logic                        pop;
    logic                        ren;
    logic [2:0]                  occ_sum;

    assign accept = (state == ST_IDLE) && start_i && (len_i != '0);
    assign valid  = (state == ST_XFER) && (buf_count != 2'd0);
    assign pop    = valid && tx.chnl_tx_data_ren_i;

    // An entry leaving this cycle frees its slot for a new read, which is what
    // keeps the 2-entry buffer at one beat per cycle across the read latency.
    assign occ_sum = {1'b0, buf_count} - {2'b00, pop} + {2'b00, in_flight};
    assign ren     = ((state == ST_REQ) || (state == ST_XFER)) && !tx.fifo_empty_i
                     && (fetch_cnt != '0) && (occ_sum < 3'd2);

    iob_pcie_tx_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .rd        (ren),
        .pop       (pop),
        .data_in   (tx.fifo_data_i),
        .head      (head),
        .count     (buf_count),
        .in_flight (in_flight)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            last_q    <= 1'b0;
            beat_cnt  <= '0;
            fetch_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                len_q     <= len_i;
                last_q    <= last_i;
                beat_cnt  <= beat_count(len_i);
                fetch_cnt <= beat_count(len_i);
            end else begin
                if (pop) beat_cnt <= beat_cnt - DATA_W'(1);
                if (ren) fetch_cnt <= fetch_cnt - DATA_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        tx.chnl_tx_o = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (accept) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                tx.chnl_tx_o = 1'b1;
                if (tx.chnl_tx_ack_i) state_nxt = ST_XFER;
            end
            ST_XFER: begin
                tx.chnl_tx_o = 1'b1;
                if (pop && (beat_cnt == DATA_W'(1))) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign tx.fifo_ren_o           = ren;
    assign tx.chnl_tx_last_o       = last_q;
    assign tx.chnl_tx_len_o        = len_q;
    assign tx.chnl_tx_off_o        = '0;
    assign tx.chnl_tx_data_o       = head;
    assign tx.chnl_tx_data_valid_o = valid;

endmodule

// File: tb/tb_iob_pcie_tx_ctrl.sv
// Directed bench for iob_pcie_tx_ctrl with a behavioural TX FIFO and beat monitor.
// Stimulus changes 1 ns after the rising edge; the monitor samples on the falling edge.
module tb_iob_pcie_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] len_i;
    logic        last_i;
    logic        busy;
    logic        done;
    logic        stall;

    iob_pcie_tx_ctrl_if tx_if ();

    iob_pcie_tx_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .len_i   (len_i),
        .last_i  (last_i),
        .busy_o  (busy),
        .done_o  (done),
        .tx      (tx_if)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: read data appears one cycle after the read enable.
    logic [63:0] fifo_mem [64];
    int          wr_idx = 0;
    int          rd_idx = 0;

    assign tx_if.fifo_empty_i = stall || (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (tx_if.fifo_ren_o) begin
            tx_if.fifo_data_i <= fifo_mem[rd_idx];
            rd_idx            <= rd_idx + 1;
        end
    end

    int          cyc = 0;
    logic [63:0] beat_log [64];
    int          beat_cyc [64];
    int          nbeats = 0;
    int          ndone = 0;
    int          done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (tx_if.chnl_tx_data_valid_o && tx_if.chnl_tx_data_ren_i && nbeats < 64) begin
                beat_log[nbeats] = tx_if.chnl_tx_data_o;
                beat_cyc[nbeats] = cyc;
                nbeats = nbeats + 1;
            end
            if (done) begin
                ndone    = ndone + 1;
                done_cyc = cyc;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int b, d, r;

    function automatic logic [63:0] pat(input int k);
        return {32'hC0DE_0000 + 32'(k), 32'h5A00_0000 + 32'(k)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] len, input logic last);
        start_i = 1'b1;
        len_i   = len;
        last_i  = last;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_idx] = pat(wr_idx);
            wr_idx = wr_idx + 1;
        end
    endtask

    task automatic waitDone(input int base, input string tag);
        for (int i = 0; i < 80 && ndone == base; i++) tick(1);
        checkOutput(tag, 64'(ndone - base), 64'd1);
    endtask

    task automatic ackNow();
        tx_if.chnl_tx_ack_i = 1'b1;
        tick(1);
        tx_if.chnl_tx_ack_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        len_i = '0;
        last_i = 1'b0;
        stall = 1'b0;
        tx_if.chnl_tx_ack_i = 1'b0;
        tx_if.chnl_tx_data_ren_i = 1'b0;
        tick(2);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_chnl_tx", 64'(tx_if.chnl_tx_o), 64'd0);
        checkOutput("rst_ren", 64'(tx_if.fifo_ren_o), 64'd0);
        checkOutput("rst_valid", 64'(tx_if.chnl_tx_data_valid_o), 64'd0);
        checkOutput("rst_data", tx_if.chnl_tx_data_o, 64'd0);
        checkOutput("rst_len", 64'(tx_if.chnl_tx_len_o), 64'd0);
        checkOutput("rst_last", 64'(tx_if.chnl_tx_last_o), 64'd0);
        checkOutput("rst_off", 64'(tx_if.chnl_tx_off_o), 64'd0);
        rst = 1'b0;
        tick(1);

        // len=8, FIFO preloaded, ACK three cycles after chnl_tx rises
        preload(4);
        tx_if.chnl_tx_data_ren_i = 1'b1;
        b = nbeats; d = ndone; r = rd_idx;
        applyStimulus(32'd8, 1'b1);
        checkOutput("t1_chnl_tx", 64'(tx_if.chnl_tx_o), 64'd1);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        checkOutput("t1_first_ren", 64'(tx_if.fifo_ren_o), 64'd1);
        checkOutput("t1_len", 64'(tx_if.chnl_tx_len_o), 64'd8);
        checkOutput("t1_last", 64'(tx_if.chnl_tx_last_o), 64'd1);
        tick(3);
        ackNow();
        waitDone(d, "t1_done");
        checkOutput("t1_nbeats", 64'(nbeats - b), 64'd4);
        for (int i = 0; i < 4; i++) checkOutput("t1_beat", beat_log[b + i], pat(i));
        checkOutput("t1_back_to_back", 64'(beat_cyc[b + 3] - beat_cyc[b]), 64'd3);
        checkOutput("t1_done_lat", 64'(done_cyc - beat_cyc[b + 3]), 64'd1);
        checkOutput("t1_reads", 64'(rd_idx - r), 64'd4);
        checkOutput("t1_idle_busy", 64'(busy), 64'd0);
        checkOutput("t1_idle_chnl_tx", 64'(tx_if.chnl_tx_o), 64'd0);

        // len=5: three beats, no read past the beat count
        preload(4);
        b = nbeats; d = ndone; r = rd_idx;
        applyStimulus(32'd5, 1'b0);
        ackNow();
        waitDone(d, "t2_done");
        checkOutput("t2_nbeats", 64'(nbeats - b), 64'd3);
        checkOutput("t2_beat0", beat_log[b], pat(4));
        checkOutput("t2_beat2_lo", 64'(beat_log[b + 2][31:0]), 64'(32'h5A00_0006));
        tick(3);
        checkOutput("t2_reads", 64'(rd_idx - r), 64'd3);

        // len=12 with ren toggling and the FIFO stalled for five cycles
        preload(5);
        tx_if.chnl_tx_data_ren_i = 1'b0;
        b = nbeats; d = ndone; r = rd_idx;
        applyStimulus(32'd12, 1'b0);
        ackNow();
        for (int k = 1; k <= 5; k++) begin
            tx_if.chnl_tx_data_ren_i = k[0];
            tick(1);
        end
        stall = 1'b1;
        for (int k = 6; k <= 10; k++) begin
            tx_if.chnl_tx_data_ren_i = k[0];
            if (k == 10) checkOutput("t3_stall_valid", 64'(tx_if.chnl_tx_data_valid_o), 64'd0);
            tick(1);
        end
        stall = 1'b0;
        for (int k = 11; k < 80 && ndone == d; k++) begin
            tx_if.chnl_tx_data_ren_i = k[0];
            tick(1);
        end
        checkOutput("t3_done", 64'(ndone - d), 64'd1);
        checkOutput("t3_nbeats", 64'(nbeats - b), 64'd6);
        for (int i = 0; i < 6; i++) checkOutput("t3_beat", beat_log[b + i], pat(7 + i));
        checkOutput("t3_reads", 64'(rd_idx - r), 64'd6);
        tx_if.chnl_tx_data_ren_i = 1'b1;

        // len=0 is ignored; a start while busy is ignored
        preload(2);
        d = ndone; r = rd_idx;
        applyStimulus(32'd0, 1'b1);
        tick(2);
        checkOutput("t4_zero_busy", 64'(busy), 64'd0);
        checkOutput("t4_zero_chnl_tx", 64'(tx_if.chnl_tx_o), 64'd0);
        checkOutput("t4_zero_done", 64'(ndone - d), 64'd0);
        checkOutput("t4_zero_reads", 64'(rd_idx - r), 64'd0);
        b = nbeats;
        applyStimulus(32'd4, 1'b1);
        applyStimulus(32'd10, 1'b0);
        checkOutput("t4_len_kept", 64'(tx_if.chnl_tx_len_o), 64'd4);
        checkOutput("t4_last_kept", 64'(tx_if.chnl_tx_last_o), 64'd1);
        ackNow();
        waitDone(d, "t4_done");
        checkOutput("t4_nbeats", 64'(nbeats - b), 64'd2);
        checkOutput("t4_beat0", beat_log[b], pat(13));
        checkOutput("t4_beat1", beat_log[b + 1], pat(14));
        checkOutput("t4_reads", 64'(rd_idx - r), 64'd2);
        checkOutput("t4_len_after", 64'(tx_if.chnl_tx_len_o), 64'd4);

        // reset after two of four beats, then a clean len=2 transfer
        preload(4);
        b = nbeats;
        applyStimulus(32'd8, 1'b1);
        ackNow();
        for (int i = 0; i < 40 && (nbeats - b) < 2; i++) tick(1);
        checkOutput("t5_two_beats", 64'(nbeats - b), 64'd2);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_chnl_tx", 64'(tx_if.chnl_tx_o), 64'd0);
        checkOutput("t5_rst_busy", 64'(busy), 64'd0);
        checkOutput("t5_rst_done", 64'(done), 64'd0);
        checkOutput("t5_rst_valid", 64'(tx_if.chnl_tx_data_valid_o), 64'd0);
        checkOutput("t5_rst_ren", 64'(tx_if.fifo_ren_o), 64'd0);
        checkOutput("t5_rst_data", tx_if.chnl_tx_data_o, 64'd0);
        checkOutput("t5_rst_len", 64'(tx_if.chnl_tx_len_o), 64'd0);
        checkOutput("t5_rst_last", 64'(tx_if.chnl_tx_last_o), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        preload(1);
        b = nbeats; d = ndone; r = rd_idx;
        applyStimulus(32'd2, 1'b1);
        ackNow();
        waitDone(d, "t5_post_done");
        checkOutput("t5_post_nbeats", 64'(nbeats - b), 64'd1);
        checkOutput("t5_post_beat", beat_log[b], pat(r));
        checkOutput("t5_post_reads", 64'(rd_idx - r), 64'd1);

        // maximum length: beat count must not overflow
        applyStimulus(32'hFFFF_FFFF, 1'b1);
        checkOutput("t6_beat_cnt", 64'(dut.beat_cnt), 64'h8000_0000);
        checkOutput("t6_len", 64'(tx_if.chnl_tx_len_o), 64'hFFFF_FFFF);
        checkOutput("t6_chnl_tx", 64'(tx_if.chnl_tx_o), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_busy", 64'(busy), 64'd0);
        checkOutput("t6_rst_chnl_tx", 64'(tx_if.chnl_tx_o), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
